pong_game_engine: RTL and testbench



---
 rtl/pong_game_engine_if.sv | 31 +++
 rtl/pong_game_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_pong_game_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_engine_if.sv
// Frame-rate link between the game engine and its driver/renderer side.
// The master drives the frame tick and buttons; the slave publishes object state.
interface pong_game_engine_if;
    logic       frame_tick;
    logic       btn_top_l;
    logic       btn_top_r;
    logic       btn_bot_l;
    logic       btn_bot_r;
    logic       btn_start;
    logic [9:0] top_paddle_x;
    logic [9:0] bot_paddle_x;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_top;
    logic [3:0] score_bot;
    logic [1:0] game_state;
    logic       winner;
    logic       point_pulse;

    modport master (
        output frame_tick, btn_top_l, btn_top_r, btn_bot_l, btn_bot_r, btn_start,
        input  top_paddle_x, bot_paddle_x, ball_x, ball_y,
        input  score_top, score_bot, game_state, winner, point_pulse
    );

    modport slave (
        input  frame_tick, btn_top_l, btn_top_r, btn_bot_l, btn_bot_r, btn_start,
        output top_paddle_x, bot_paddle_x, ball_x, ball_y,
        output score_top, score_bot, game_state, winner, point_pulse
    );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game-state engine: paddles, ball, collisions, scoring and match FSM,
// advancing once per frame_tick; all published coordinates are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ball centred, paddles frozen, waiting for btn_start
// S_SERVE   | ball held at centre for SERVE_FRAMES ticks, paddles move
// S_PLAY    | paddles and ball move, collisions and misses resolved
// S_OVER    | everything frozen until btn_start begins a new match
module pong_game_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 40,
    parameter int PADDLE_H     = 20,
    parameter int TOP_PADDLE_Y = 100,
    parameter int BOT_PADDLE_Y = 360,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    pong_game_engine_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [10:0] PAD_MAX    = 11'(SCREEN_W - PADDLE_W);
    localparam logic [10:0] BALL_MAX_X = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] BALL_MAX_Y = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] STEP_P     = 11'(PADDLE_STEP);
    localparam logic [10:0] STEP_B     = 11'(BALL_STEP);
    localparam logic [10:0] SIZE_B     = 11'(BALL_SIZE);
    localparam logic [10:0] PW         = 11'(PADDLE_W);
    localparam logic [10:0] BOT_Y      = 11'(BOT_PADDLE_Y);
    localparam logic [10:0] TOP_EDGE   = 11'(TOP_PADDLE_Y + PADDLE_H);
    localparam logic [9:0]  PAD_HOME   = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0]  HOME_X     = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  HOME_Y     = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

    state_t     state;
    logic [9:0] top_px, bot_px, ball_x, ball_y;
    logic       dir_x, dir_y;
    logic [3:0] score_top, score_bot;
    logic       winner, point_pulse;
    logic [7:0] serve_cnt;

    logic [9:0]  top_next, bot_next;
    logic [10:0] bx, by, tpx, bpx, ny_dn, ny_up;
    logic [9:0]  nx, ny;
    logic        ndir_x, ndir_y;
    logic        ov_top, ov_bot, hit_top, hit_bot, miss_top, miss_bot;

    function automatic logic [9:0] paddle_next(input logic [9:0] p,
                                               input logic move_l,
                                               input logic move_r);
        logic [10:0] w;
        w = {1'b0, p};
        if (move_l && !move_r)
            w = (w <= STEP_P) ? 11'd0 : w - STEP_P;
        else if (move_r && !move_l)
            w = (w + STEP_P >= PAD_MAX) ? PAD_MAX : w + STEP_P;
        return 10'(w);
    endfunction

    always_comb begin
        top_next = paddle_next(top_px, bus.btn_top_l, bus.btn_top_r);
        bot_next = paddle_next(bot_px, bus.btn_bot_l, bus.btn_bot_r);
    end

    // Ball resolution uses the paddle positions registered before this tick.
    always_comb begin
        bx    = {1'b0, ball_x};
        by    = {1'b0, ball_y};
        tpx   = {1'b0, top_px};
        bpx   = {1'b0, bot_px};
        ny_dn = by + STEP_B;
        ny_up = (by > STEP_B) ? by - STEP_B : 11'd0;

        ndir_x = dir_x;
        if (dir_x) begin
            if (bx + STEP_B >= BALL_MAX_X) begin
                nx     = 10'(BALL_MAX_X);
                ndir_x = 1'b0;
            end else begin
                nx = 10'(bx + STEP_B);
            end
        end else begin
            if (bx <= STEP_B) begin
                nx     = 10'd0;
                ndir_x = 1'b1;
            end else begin
                nx = 10'(bx - STEP_B);
            end
        end

        ov_top   = (bx + SIZE_B > tpx) && (bx < tpx + PW);
        ov_bot   = (bx + SIZE_B > bpx) && (bx < bpx + PW);
        hit_bot  = dir_y && ov_bot && (by + SIZE_B <= BOT_Y) && (ny_dn + SIZE_B >= BOT_Y);
        hit_top  = !dir_y && ov_top && (by >= TOP_EDGE) && (ny_up <= TOP_EDGE);
        miss_bot = dir_y && !hit_bot && (ny_dn >= BALL_MAX_Y);
        miss_top = !dir_y && !hit_top && (by <= STEP_B);

        ndir_y = dir_y;
        ny     = dir_y ? 10'(ny_dn) : 10'(ny_up);
        if (hit_bot) begin
            ny     = 10'(BOT_Y - SIZE_B);
            ndir_y = 1'b0;
        end else if (hit_top) begin
            ny     = 10'(TOP_EDGE);
            ndir_y = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            top_px      <= PAD_HOME;
            bot_px      <= PAD_HOME;
            ball_x      <= HOME_X;
            ball_y      <= HOME_Y;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            score_top   <= 4'd0;
            score_bot   <= 4'd0;
            winner      <= 1'b0;
            point_pulse <= 1'b0;
            serve_cnt   <= 8'd0;
        end else begin
            point_pulse <= 1'b0;
            if (bus.frame_tick) begin
                case (state)
                    S_IDLE: begin
                        if (bus.btn_start) begin
                            state     <= S_SERVE;
                            score_top <= 4'd0;
                            score_bot <= 4'd0;
                            serve_cnt <= 8'd0;
                        end
                    end
                    S_SERVE: begin
                        top_px <= top_next;
                        bot_px <= bot_next;
                        ball_x <= HOME_X;
                        ball_y <= HOME_Y;
                        if (serve_cnt == SERVE_LAST) begin
                            state     <= S_PLAY;
                            serve_cnt <= 8'd0;
                        end else begin
                            serve_cnt <= serve_cnt + 8'd1;
                        end
                    end
                    S_PLAY: begin
                        top_px <= top_next;
                        bot_px <= bot_next;
                        if (miss_bot || miss_top) begin
                            // Direction is kept across the point so the next serve
                            // heads the same way.
                            point_pulse <= 1'b1;
                            ball_x      <= HOME_X;
                            ball_y      <= HOME_Y;
                            serve_cnt   <= 8'd0;
                            if (miss_bot) begin
                                score_top <= score_top + 4'd1;
                                if (score_top + 4'd1 == WIN) begin
                                    state  <= S_OVER;
                                    winner <= 1'b0;
                                end else begin
                                    state <= S_SERVE;
                                end
                            end else begin
                                score_bot <= score_bot + 4'd1;
                                if (score_bot + 4'd1 == WIN) begin
                                    state  <= S_OVER;
                                    winner <= 1'b1;
                                end else begin
                                    state <= S_SERVE;
                                end
                            end
                        end else begin
                            ball_x <= nx;
                            ball_y <= ny;
                            dir_x  <= ndir_x;
                            dir_y  <= ndir_y;
                        end
                    end
                    S_OVER: begin
                        if (bus.btn_start) begin
                            state     <= S_SERVE;
                            score_top <= 4'd0;
                            score_bot <= 4'd0;
                            top_px    <= PAD_HOME;
                            bot_px    <= PAD_HOME;
                            ball_x    <= HOME_X;
                            ball_y    <= HOME_Y;
                            serve_cnt <= 8'd0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.top_paddle_x = top_px;
    assign bus.bot_paddle_x = bot_px;
    assign bus.ball_x       = ball_x;
    assign bus.ball_y       = ball_y;
    assign bus.score_top    = score_top;
    assign bus.score_bot    = score_bot;
    assign bus.game_state   = state;
    assign bus.winner       = winner;
    assign bus.point_pulse  = point_pulse;
endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: serve timing, paddle saturation, wall and
// paddle bounces, scoring to game over, restart and asynchronous reset.
module tb_pong_game_engine;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pong_game_engine_if bus();

    pong_game_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick; returns on the falling edge after the updating rising edge.
    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, ".x"}, bus.ball_x, x);
        check({tag, ".y"}, bus.ball_y, y);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".top"},    bus.top_paddle_x, 300);
        check({tag, ".bot"},    bus.bot_paddle_x, 300);
        check_ball(tag, 316, 236);
        check({tag, ".st"},     bus.score_top, 0);
        check({tag, ".sb"},     bus.score_bot, 0);
        check({tag, ".state"},  bus.game_state, 0);
        check({tag, ".winner"}, bus.winner, 0);
        check({tag, ".pulse"},  bus.point_pulse, 0);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.btn_top_l  = 1'b0;
        bus.btn_top_r  = 1'b0;
        bus.btn_bot_l  = 1'b0;
        bus.btn_bot_r  = 1'b0;
        bus.btn_start  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        // IDLE: paddles frozen, no start -> nothing changes
        bus.btn_top_l = 1'b1;
        tick();
        bus.btn_top_l = 1'b0;
        check("idle.state", bus.game_state, 0);
        check("idle.top", bus.top_paddle_x, 300);
        check_ball("idle", 316, 236);

        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        check("serve.state", bus.game_state, 1);

        // Serve: both top buttons -> hold; bottom right 30 ticks -> 420
        bus.btn_top_l = 1'b1;
        bus.btn_top_r = 1'b1;
        bus.btn_bot_r = 1'b1;
        ticks(30);
        bus.btn_bot_r = 1'b0;
        check("serve.bot", bus.bot_paddle_x, 420);
        check("serve.top_both", bus.top_paddle_x, 300);
        check_ball("serve.held", 316, 236);
        ticks(29);
        check("serve.59", bus.game_state, 1);
        tick();
        check("serve.60", bus.game_state, 2);
        check_ball("play.t0", 316, 236);

        // Play: top paddle drives right toward 600
        bus.btn_top_l = 1'b0;
        tick();
        check_ball("play.t1", 318, 238);
        check("play.top1", bus.top_paddle_x, 304);
        ticks(56);
        check_ball("play.t57", 430, 350);
        check("play.top57", bus.top_paddle_x, 528);
        tick();
        check_ball("bot_hit", 432, 352);
        check("bot_hit.pulse", bus.point_pulse, 0);
        check("bot_hit.state", bus.game_state, 2);
        tick();
        check_ball("bot_hit.after", 434, 350);
        ticks(15);
        check("top.t74", bus.top_paddle_x, 596);
        tick();
        check("top.t75", bus.top_paddle_x, 600);
        tick();
        check("top.sat600", bus.top_paddle_x, 600);
        check_ball("play.t76", 468, 316);
        ticks(82);
        check_ball("xwall", 632, 152);
        tick();
        check_ball("xwall.after", 630, 150);
        ticks(14);
        check_ball("play.t173", 602, 122);
        tick();
        check_ball("top_hit", 600, 120);
        tick();
        check_ball("top_hit.after", 598, 122);
        bus.btn_top_r = 1'b0;

        // Ball heads down past the bottom paddle at 420 and misses
        ticks(174);
        check_ball("play.t349", 250, 470);
        check("pre_miss.pulse", bus.point_pulse, 0);
        tick();
        check("miss1.pulse", bus.point_pulse, 1);
        check("miss1.st", bus.score_top, 1);
        check("miss1.sb", bus.score_bot, 0);
        check("miss1.state", bus.game_state, 1);
        check_ball("miss1", 316, 236);
        @(negedge clk);
        check("miss1.pulse_off", bus.point_pulse, 0);

        // Points 2..5, ball now serves toward -x,+y; top paddle driven left
        bus.btn_top_l = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            ticks(59);
            check("loop.serve59", bus.game_state, 1);
            tick();
            check("loop.serve60", bus.game_state, 2);
            tick();
            check_ball("loop.t1", 314, 238);
            if (k == 2) check("loop.top61", bus.top_paddle_x, 356);
            ticks(116);
            check_ball("loop.t117", 82, 470);
            tick();
            check("loop.pulse", bus.point_pulse, 1);
            check("loop.st", bus.score_top, k);
            check("loop.state", bus.game_state, (k == 5) ? 3 : 1);
            check_ball("loop.centre", 316, 236);
        end
        check("top.sat0", bus.top_paddle_x, 0);
        check("over.winner", bus.winner, 0);
        check("over.sb", bus.score_bot, 0);

        // GAME_OVER: everything frozen
        bus.btn_top_l = 1'b0;
        bus.btn_top_r = 1'b1;
        bus.btn_bot_l = 1'b1;
        tick();
        check("over.state", bus.game_state, 3);
        check("over.top", bus.top_paddle_x, 0);
        check("over.bot", bus.bot_paddle_x, 420);
        check("over.st", bus.score_top, 5);
        check("over.pulse", bus.point_pulse, 0);
        bus.btn_top_r = 1'b0;
        bus.btn_bot_l = 1'b0;

        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        check("restart.state", bus.game_state, 1);
        check("restart.st", bus.score_top, 0);
        check("restart.top", bus.top_paddle_x, 300);
        check("restart.bot", bus.bot_paddle_x, 300);

        ticks(60);
        ticks(10);
        check("play2.state", bus.game_state, 2);
        check_ball("play2.t10", 296, 256);

        // Asynchronous reset mid-cycle during play
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async.state", bus.game_state, 0);
        check_ball("async", 316, 236);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
